jp_dev: RTL and testbench



---
 rtl/jp_dev_if.sv | 9 +
 rtl/jp_dev.sv | 92 +++++++++
 tb/tb_jp_dev.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/jp_dev_if.sv
// Controller-port bundle between an NES console (master) and the joypad responder (slave).
interface jp_dev_if;
  logic jp_latch;
  logic jp_clk;
  logic jp_data;

  modport master (output jp_latch, output jp_clk, input jp_data);
  modport slave  (input jp_latch, input jp_clk, output jp_data);
endinterface

// File: rtl/jp_dev.sv
// NES controller responder: 4021-style shift register answering console latch/clock.
// Optional turbo on A/B is enabled with `define JP_DEV_TURBO_EN.
module jp_dev #(
  parameter int SYNC_STAGES  = 2,
  parameter int TURBO_PERIOD = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  buttons,
  input  logic [1:0]  turbo,
  jp_dev_if.slave     jp,
  output logic [3:0]  bit_cnt,
  output logic        frame_strobe
);

  logic [SYNC_STAGES-1:0] latch_sync;
  logic [SYNC_STAGES-1:0] clk_sync;
  logic                   latch_s;
  logic                   clk_s;
  logic                   latch_q;
  logic                   clk_q;
  logic                   latch_fall;
  logic                   clk_rise;
  logic                   shift_en;
  logic [7:0]             sr;
  logic [7:0]             eff_buttons;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      latch_sync <= '0;
      clk_sync   <= '0;
      latch_q    <= 1'b0;
      clk_q      <= 1'b0;
    end else begin
      latch_sync <= {latch_sync[SYNC_STAGES-2:0], jp.jp_latch};
      clk_sync   <= {clk_sync[SYNC_STAGES-2:0], jp.jp_clk};
      latch_q    <= latch_s;
      clk_q      <= clk_s;
    end
  end

  assign latch_s    = latch_sync[SYNC_STAGES-1];
  assign clk_s      = clk_sync[SYNC_STAGES-1];
  assign latch_fall = latch_q & ~latch_s;
  assign clk_rise   = ~clk_q & clk_s;
  // A clock edge arriving with the latch fall is dropped so A is always shown first.
  assign shift_en   = ~latch_s & clk_rise & ~latch_fall;

`ifdef JP_DEV_TURBO_EN
  localparam int TW = $clog2(TURBO_PERIOD);

  logic [TW-1:0] turbo_cnt;
  logic          phase_on;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      turbo_cnt <= '0;
    end else if (latch_fall) begin
      turbo_cnt <= (turbo_cnt == TW'(TURBO_PERIOD - 1)) ? '0 : turbo_cnt + 1'b1;
    end
  end

  assign phase_on    = (turbo_cnt < TW'(TURBO_PERIOD / 2));
  assign eff_buttons = {buttons[7:2], buttons[1:0] & (~turbo | {2{phase_on}})};
`else
  logic unused_turbo;

  assign unused_turbo = ^turbo ^ TURBO_PERIOD[0];
  assign eff_buttons  = buttons;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr           <= '0;
      jp.jp_data   <= 1'b1;
      bit_cnt      <= '0;
      frame_strobe <= 1'b0;
    end else begin
      frame_strobe <= latch_fall;
      jp.jp_data   <= ~sr[0];
      if (latch_s) begin
        sr      <= eff_buttons;
        bit_cnt <= '0;
      end else if (shift_en) begin
        // Pressed-high 1s fill from the top, so the line reads "pressed" after bit 8.
        sr      <= {1'b1, sr[7:1]};
        bit_cnt <= (bit_cnt == 4'd8) ? 4'd8 : bit_cnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_jp_dev.sv
// Directed bench for jp_dev: a console-style host drives frames and checks reads via a scoreboard.
module tb_jp_dev;
  logic       clk;
  logic       rst_n;
  logic [7:0] buttons;
  logic [1:0] turbo;
  logic [3:0] bit_cnt;
  logic       frame_strobe;

  jp_dev_if jp ();

  jp_dev #(.SYNC_STAGES(2), .TURBO_PERIOD(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .buttons      (buttons),
    .turbo        (turbo),
    .jp           (jp.slave),
    .bit_cnt      (bit_cnt),
    .frame_strobe (frame_strobe)
  );

  int   checks = 0;
  int   errors = 0;
  int   strobe_cnt = 0;
  logic exp_q[$];

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(posedge clk) if (frame_strobe === 1'b1) strobe_cnt++;

  initial begin
    #5ms;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sample(input string tag);
    logic e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed empty scoreboard expected entry", tag);
    end else begin
      e = exp_q.pop_front();
      check(tag, {7'd0, ~jp.jp_data}, {7'd0, e});
    end
  endtask

  // mode 0: plain frame; 1: clock pulses during latch; 2: latch fall coincident with clock rise
  task automatic run_frame(input logic [7:0] exp_byte, input int n_clk, input int mode,
                           input int change_after);
    int sb;
    jp.jp_latch = 1'b1;
    jp.jp_clk   = 1'b0;
    if (mode == 1) begin
      for (int i = 0; i < 3; i++) begin
        wait_cyc(4); jp.jp_clk = 1'b1;
        wait_cyc(4); jp.jp_clk = 1'b0;
      end
      wait_cyc(16);
      check("cnt_in_latch", {4'd0, bit_cnt}, 8'd0);
    end else begin
      wait_cyc(16);
    end
    exp_q.push_back(exp_byte[0]);
    for (int k = 1; k <= n_clk; k++) exp_q.push_back((k < 8) ? exp_byte[k] : 1'b1);
    sb = strobe_cnt;
    if (mode == 2) begin
      jp.jp_latch = 1'b0;
      jp.jp_clk   = 1'b1;
      wait_cyc(16);
      sample("read_a");
      jp.jp_clk = 1'b0;
      wait_cyc(16);
    end else begin
      jp.jp_latch = 1'b0;
      wait_cyc(16);
      sample("read_a");
    end
    check("cnt_after_latch", {4'd0, bit_cnt}, 8'd0);
    check("strobe_once", 8'(strobe_cnt - sb), 8'd1);
    for (int k = 1; k <= n_clk; k++) begin
      jp.jp_clk = 1'b1;
      wait_cyc(16);
      sample($sformatf("read_%0d", k));
      jp.jp_clk = 1'b0;
      wait_cyc(16);
      if (k == change_after) buttons = 8'h00;
    end
    check("cnt_end", {4'd0, bit_cnt}, (n_clk > 8) ? 8'd8 : 8'(n_clk));
    check("sb_drained", 8'(exp_q.size()), 8'd0);
    wait_cyc(32);
  endtask

  logic [7:0] turbo_a;

  initial begin
`ifdef JP_DEV_TURBO_EN
    turbo_a = 8'b0011_0011;
`else
    turbo_a = 8'b1111_1111;
`endif
    rst_n       = 1'b0;
    jp.jp_latch = 1'b1;
    jp.jp_clk   = 1'b0;
    buttons     = 8'hFF;
    turbo       = 2'b00;

    // Reset while latched with all pressed: line must stay released.
    wait_cyc(2);
    for (int i = 0; i < 3; i++) begin
      check("rst_data", {7'd0, jp.jp_data}, 8'd1);
      check("rst_cnt", {4'd0, bit_cnt}, 8'd0);
      wait_cyc(2);
    end
    @(negedge clk);
    rst_n = 1'b1;
    wait_cyc(4);
    check("first_load", {7'd0, jp.jp_data}, 8'd0);
    wait_cyc(16);
    jp.jp_latch = 1'b0;
    wait_cyc(32);

    buttons = 8'h95;
    run_frame(8'h95, 7, 0, 0);
    run_frame(8'h95, 12, 0, 0);
    run_frame(8'h95, 8, 1, 0);
    run_frame(8'h95, 8, 2, 0);
    run_frame(8'h95, 8, 0, 3);
    run_frame(8'h00, 8, 0, 0);

    // Mid-frame reset.
    buttons     = 8'hFF;
    jp.jp_latch = 1'b1;
    wait_cyc(16);
    jp.jp_latch = 1'b0;
    wait_cyc(16);
    jp.jp_clk = 1'b1; wait_cyc(16);
    jp.jp_clk = 1'b0; wait_cyc(16);
    jp.jp_clk = 1'b1; wait_cyc(8);
    check("pre_rst_cnt", {4'd0, bit_cnt}, 8'd2);
    rst_n = 1'b0;
    wait_cyc(2);
    check("mid_rst_data", {7'd0, jp.jp_data}, 8'd1);
    check("mid_rst_cnt", {4'd0, bit_cnt}, 8'd0);
    check("mid_rst_strobe", {7'd0, frame_strobe}, 8'd0);
    jp.jp_clk = 1'b0;
    wait_cyc(2);
    rst_n = 1'b1;
    wait_cyc(8);

    // Turbo on A across 8 frames (counter freshly reset).
    buttons = 8'h01;
    turbo   = 2'b01;
    for (int f = 0; f < 8; f++) begin
      run_frame({7'd0, turbo_a[f]}, 0, 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
